// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM states, BCD limits and
// the bit positions of the per-digit blank vector.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } state_e;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    localparam int BLANK_MIN_TENS = 3;
    localparam int BLANK_MIN_ONES = 2;
    localparam int BLANK_SEC_TENS = 1;
    localparam int BLANK_SEC_ONES = 0;

    // Blank mask covering the two digits of the field chosen by sw_sel.
    function automatic logic [3:0] field_blank(input logic sel_sec);
        logic [3:0] b;
        b = '0;
        if (sel_sec) begin
            b[BLANK_SEC_TENS] = 1'b1;
            b[BLANK_SEC_ONES] = 1'b1;
        end else begin
            b[BLANK_MIN_TENS] = 1'b1;
            b[BLANK_MIN_ONES] = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// Two-digit BCD counter 00..59. clr wins over inc; wrap flags an increment
// out of 59 so the caller can carry into the next field.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic       src_clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    assign wrap = inc && (tens == TENS_MAX) && (ones == ONES_MAX);

    always_ff @(posedge src_clk or posedge reset) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == ONES_MAX) begin
                ones <= '0;
                tens <= (tens == TENS_MAX) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: conditions buttons and divider ticks, runs the
// IDLE/RUN/PAUSE/ADJUST machine and drives the MM:SS counters and blanking.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       src_clk,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       clk_4hz,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [3:0] blank,
    output state_e     dbg_state
);

    logic [SYNC_STAGES-1:0] pause_sync, clear_sync, adj_sync, sel_sync;
    logic pause_prev, hz1_prev, hz2_prev, hz4_prev, ticks_armed;
    logic pause_s, clear_s, adj_s, sel_s;
    logic press, tick_1, tick_2, tick_4;
    logic run_active, adj_active, sec_inc, min_inc, sec_wrap, min_wrap_unused;
    logic phase, phase_nxt;
    state_e state, state_nxt;

    always_ff @(posedge src_clk or posedge reset) begin
        if (reset) begin
            pause_sync  <= '0;
            clear_sync  <= '0;
            adj_sync    <= '0;
            sel_sync    <= '0;
            pause_prev  <= 1'b0;
            hz1_prev    <= 1'b0;
            hz2_prev    <= 1'b0;
            hz4_prev    <= 1'b0;
            ticks_armed <= 1'b0;
        end else begin
            pause_sync  <= {pause_sync[SYNC_STAGES-2:0], btn_pause};
            clear_sync  <= {clear_sync[SYNC_STAGES-2:0], btn_clear};
            adj_sync    <= {adj_sync[SYNC_STAGES-2:0], sw_adj};
            sel_sync    <= {sel_sync[SYNC_STAGES-2:0], sw_sel};
            pause_prev  <= pause_s;
            hz1_prev    <= clk_1hz;
            hz2_prev    <= clk_2hz;
            hz4_prev    <= clk_4hz;
            ticks_armed <= 1'b1;
        end
    end

    assign pause_s = pause_sync[SYNC_STAGES-1];
    assign clear_s = clear_sync[SYNC_STAGES-1];
    assign adj_s   = adj_sync[SYNC_STAGES-1];
    assign sel_s   = sel_sync[SYNC_STAGES-1];
    assign press   = pause_s & ~pause_prev;

    // The first cycle after reset only loads the previous-level registers, so
    // a divider output already high at release does not count as an edge.
    assign tick_1 = clk_1hz & ~hz1_prev & ticks_armed;
    assign tick_2 = clk_2hz & ~hz2_prev & ticks_armed;
    assign tick_4 = clk_4hz & ~hz4_prev & ticks_armed;

    // Counting uses the current state, so a tick coinciding with RUN->PAUSE
    // still lands while one coinciding with PAUSE->RUN does not.
    assign run_active = (state == ST_RUN)    && !adj_s && !clear_s;
    assign adj_active = (state == ST_ADJUST) &&  adj_s && !clear_s;
    assign sec_inc    = (run_active && tick_1) || (adj_active &&  sel_s && tick_2);
    assign min_inc    = (run_active && sec_wrap) || (adj_active && !sel_s && tick_2);
    assign phase_nxt  = phase ^ tick_4;

    always_comb begin
        state_nxt = state;
        if (clear_s) begin
            state_nxt = ST_IDLE;
        end else if (adj_s) begin
            state_nxt = ST_ADJUST;
        end else begin
            case (state)
                ST_IDLE:   if (press) state_nxt = ST_RUN;
                ST_RUN:    if (press) state_nxt = ST_PAUSE;
                ST_PAUSE:  if (press) state_nxt = ST_RUN;
                ST_ADJUST: state_nxt = ST_PAUSE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge src_clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            phase   <= 1'b0;
            blank   <= '0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == ST_RUN);
            phase   <= phase_nxt;
            blank   <= ((state_nxt == ST_ADJUST) && phase_nxt) ? field_blank(sel_s) : 4'b0000;
        end
    end

    assign dbg_state = state;

    bcd_mod60 u_sec (
        .src_clk (src_clk),
        .reset   (reset),
        .inc     (sec_inc),
        .clr     (clear_s),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .wrap    (sec_wrap)
    );

    bcd_mod60 u_min (
        .src_clk (src_clk),
        .reset   (reset),
        .inc     (min_inc),
        .clr     (clear_s),
        .tens    (min_tens),
        .ones    (min_ones),
        .wrap    (min_wrap_unused)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: the driver pushes hand-computed expected
// snapshots, the monitor pops and compares them on the falling clock edge.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic       src_clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_1hz = 1'b0, clk_2hz = 1'b0, clk_4hz = 1'b0;
    logic       btn_pause = 1'b0, btn_clear = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic       running;
    state_e     dbg_state;

    logic [22:0] exp_q[$];
    string       nm_q[$];
    int          total = 0;
    int          bad = 0;
    int          mon_cycles = 0;
    bit          done = 1'b0;

    stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
        .src_clk   (src_clk),
        .reset     (reset),
        .clk_1hz   (clk_1hz),
        .clk_2hz   (clk_2hz),
        .clk_4hz   (clk_4hz),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .sw_adj    (sw_adj),
        .sw_sel    (sw_sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .blank     (blank),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 src_clk = ~src_clk;

    // expected word: {state, running, blank, mm tens, mm ones, ss tens, ss ones}
    function automatic logic [22:0] mk(input int st, input logic run,
                                       input logic [3:0] blk, input int mm, input int ss);
        return {2'(st), run, blk, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge src_clk);
        #1;
    endtask

    task automatic pulse(input int f, input int n);
        for (int i = 0; i < n; i++) begin
            case (f)
                1:       clk_1hz = 1'b1;
                2:       clk_2hz = 1'b1;
                default: clk_4hz = 1'b1;
            endcase
            cyc(2);
            clk_1hz = 1'b0;
            clk_2hz = 1'b0;
            clk_4hz = 1'b0;
            cyc(2);
        end
    endtask

    task automatic press();
        btn_pause = 1'b1;
        cyc(5);
        btn_pause = 1'b0;
        cyc(5);
    endtask

    task automatic set_sw(input logic adj, input logic sel);
        sw_adj = adj;
        sw_sel = sel;
        cyc(4);
    endtask

    task automatic chk(input string nm, input logic [22:0] v);
        exp_q.push_back(v);
        nm_q.push_back(nm);
        @(negedge src_clk);
        cyc(1);
    endtask

    // scoreboard monitor and final report
    initial begin : monitor
        logic [22:0] e, act;
        string nm;
        forever begin
            @(negedge src_clk);
            mon_cycles++;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                act = {dbg_state, running, blank, min_tens, min_ones, sec_tens, sec_ones};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h (state/run/blank/mm/ss)", nm, act, e);
                end
            end
            if (done || mon_cycles > 20000) begin
                if (!done) begin
                    total++;
                    bad++;
                    $display("FAIL timeout: got=%0d cycles want=<20000", mon_cycles);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // stimulus
    initial begin
        cyc(3);
        chk("reset_hold", mk(0, 0, 4'b0000, 0, 0));
        reset = 1'b0;
        cyc(3);
        chk("idle_after_reset", mk(0, 0, 4'b0000, 0, 0));

        // button latency: state changes at the 3rd edge after the pad rises
        btn_pause = 1'b1;
        cyc(2);
        chk("press_not_yet", mk(0, 0, 4'b0000, 0, 0));
        chk("press_run", mk(1, 1, 4'b0000, 0, 0));
        btn_pause = 1'b0;
        cyc(5);
        pulse(1, 3);
        chk("run_3_ticks", mk(1, 1, 4'b0000, 0, 3));

        // pause and resume
        pulse(1, 7);
        chk("run_0010", mk(1, 1, 4'b0000, 0, 10));
        press();
        chk("paused", mk(2, 0, 4'b0000, 0, 10));
        pulse(1, 5);
        chk("paused_frozen", mk(2, 0, 4'b0000, 0, 10));
        press();
        pulse(1, 1);
        chk("resumed_0011", mk(1, 1, 4'b0000, 0, 11));

        // preload 59:58 via adjust, then wrap in RUN
        set_sw(1'b1, 1'b0);
        chk("adj_entry", mk(3, 0, 4'b0000, 0, 11));
        pulse(2, 59);
        chk("adj_min_59", mk(3, 0, 4'b0000, 59, 11));
        set_sw(1'b1, 1'b1);
        pulse(2, 47);
        chk("adj_5958", mk(3, 0, 4'b0000, 59, 58));
        set_sw(1'b0, 1'b1);
        chk("adj_exit_pause", mk(2, 0, 4'b0000, 59, 58));
        press();
        pulse(1, 1);
        chk("run_5959", mk(1, 1, 4'b0000, 59, 59));
        pulse(1, 1);
        chk("wrap_0000", mk(1, 1, 4'b0000, 0, 0));
        pulse(1, 1);
        chk("after_wrap", mk(1, 1, 4'b0000, 0, 1));

        // adjust seconds, modulo 60 without carry, and blinking
        set_sw(1'b1, 1'b1);
        pulse(2, 57);
        chk("adj_sec_58", mk(3, 0, 4'b0000, 0, 58));
        pulse(2, 3);
        chk("adj_sec_wrap", mk(3, 0, 4'b0000, 0, 1));
        pulse(4, 1);
        chk("blink_sec_on", mk(3, 0, 4'b0011, 0, 1));
        pulse(4, 1);
        chk("blink_sec_off", mk(3, 0, 4'b0000, 0, 1));
        set_sw(1'b1, 1'b0);
        pulse(4, 1);
        chk("blink_min_on", mk(3, 0, 4'b1100, 0, 1));
        pulse(4, 1);
        chk("blink_min_off", mk(3, 0, 4'b0000, 0, 1));
        pulse(1, 2);
        chk("adj_ignores_1hz", mk(3, 0, 4'b0000, 0, 1));
        press();
        chk("adj_ignores_pause", mk(3, 0, 4'b0000, 0, 1));

        // set up 12:34 in RUN
        pulse(2, 12);
        set_sw(1'b1, 1'b1);
        pulse(2, 33);
        chk("adj_1234", mk(3, 0, 4'b0000, 12, 34));
        set_sw(1'b0, 1'b1);
        press();
        chk("run_1234", mk(1, 1, 4'b0000, 12, 34));

        // clear collides with a 1 Hz tick and a pause press
        btn_clear = 1'b1;
        btn_pause = 1'b1;
        cyc(2);
        clk_1hz = 1'b1;
        cyc(1);
        chk("clear_priority", mk(0, 0, 4'b0000, 0, 0));
        clk_1hz = 1'b0;
        cyc(2);
        pulse(1, 2);
        chk("clear_hold_ticks", mk(0, 0, 4'b0000, 0, 0));
        btn_pause = 1'b0;
        btn_clear = 1'b0;
        cyc(5);
        chk("clear_release", mk(0, 0, 4'b0000, 0, 0));

        // asynchronous reset at 07:42 in ADJUST
        set_sw(1'b1, 1'b0);
        pulse(2, 7);
        set_sw(1'b1, 1'b1);
        pulse(2, 42);
        chk("adj_0742", mk(3, 0, 4'b0000, 7, 42));
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", mk(0, 0, 4'b0000, 0, 0));
        sw_adj = 1'b0;
        sw_sel = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("post_reset_idle", mk(0, 0, 4'b0000, 0, 0));
        press();
        pulse(1, 1);
        chk("restart_count", mk(1, 1, 4'b0000, 0, 1));

        done = 1'b1;
    end

endmodule
